// File: rtl/contador_decrescente.sv
// contador_decrescente: loadable down-counter with terminal-count pulse and
// optional auto-reload of the last loaded start value.
module contador_decrescente #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             auto,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] r_q;
  logic             tc_q;

  // Control FSM, count register, reload register and terminal-count pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      r_q     <= '0;
      tc_q    <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load) begin
        y_q     <= d;
        r_q     <= d;
        state_q <= (d != '0) ? RUN : IDLE;
      end else if (state_q == RUN && w) begin
        if (y_q > ONE) begin
          y_q <= y_q - ONE;
        end else begin
          // y_q is 1 here: RUN is never entered or kept with a zero count.
          tc_q <= 1'b1;
          if (auto) begin
            y_q <= r_q;
          end else begin
            y_q     <= '0;
            state_q <= DONE;
          end
        end
      end
    end
  end

  assign y    = y_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_contador_decrescente.sv
// Scoreboard bench for contador_decrescente: driver pushes expected outputs
// from a behavioural model, monitor pops and compares after each edge.
module tb_contador_decrescente;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst, w, load, auto;
  logic [W-1:0] d;
  logic [W-1:0] y;
  logic         busy, done, tc;

  contador_decrescente #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .w   (w),
    .load(load),
    .d   (d),
    .auto(auto),
    .y   (y),
    .busy(busy),
    .done(done),
    .tc  (tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    bit busy;
    bit done;
    bit tc;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  // Behavioural model: a counter that is either counting, finished, or parked.
  int m_cnt    = 0;
  int m_start  = 0;
  bit m_counting = 0;
  bit m_finished = 0;

  task automatic cyc(input bit r_v, input bit l_v, input int d_v,
                     input bit w_v, input bit a_v);
    exp_t e;
    bit   pulse;
    @(negedge clk);
    rst  = r_v;
    load = l_v;
    d    = W'(d_v);
    w    = w_v;
    auto = a_v;
    pulse = 0;
    if (r_v) begin
      m_cnt = 0; m_start = 0; m_counting = 0; m_finished = 0;
    end else if (l_v) begin
      m_cnt = d_v; m_start = d_v;
      m_counting = (d_v != 0);
      m_finished = 0;
    end else if (m_counting && w_v) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        pulse = 1;
        if (a_v) m_cnt = m_start;
        else begin
          m_counting = 0;
          m_finished = 1;
        end
      end
    end
    e.y = m_cnt; e.busy = m_counting; e.done = m_finished; e.tc = pulse;
    e.idx = cyc_n;
    cyc_n++;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (int'(y) != e.y || busy !== e.busy || done !== e.done || tc !== e.tc) begin
        errors++;
        $display("FAIL cycle%0d: got y=%0d busy=%0b done=%0b tc=%0b, expected y=%0d busy=%0b done=%0b tc=%0b",
                 e.idx, y, busy, done, tc, e.y, e.busy, e.done, e.tc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; load = 1'b0; w = 1'b0; auto = 1'b0; d = '0;

    // reset state
    repeat (2) cyc(1, 0, 0, 0, 0);

    // load 5, count to zero without auto, then extra enables
    cyc(0, 1, 5, 0, 0);
    repeat (7) cyc(0, 0, 0, 1, 0);

    // load 3 with auto-reload
    cyc(0, 1, 3, 0, 1);
    repeat (7) cyc(0, 0, 0, 1, 1);

    // restart mid-count with load and w together
    cyc(0, 1, 6, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 2, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);

    // alternating enable
    cyc(0, 1, 4, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, (i % 2) == 0, 0);

    // load zero
    cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);

    // reset overrides load and w mid-count
    cyc(0, 1, 7, 0, 0);
    repeat (4) cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 5, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);

    // auto-reload with start value 1: tc every enabled cycle
    cyc(0, 1, 1, 0, 1);
    repeat (4) cyc(0, 0, 0, 1, 1);

    // maximum start value
    cyc(0, 1, 7, 0, 0);
    repeat (8) cyc(0, 0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit r_v, l_v, w_v, a_v;
      int d_v;
      r_v = ($urandom_range(0, 49) == 0);
      l_v = ($urandom_range(0, 9) == 0);
      w_v = ($urandom_range(0, 3) != 0);
      a_v = $urandom_range(0, 1) == 1;
      d_v = int'($urandom_range(0, (1 << W) - 1));
      cyc(r_v, l_v, d_v, w_v, a_v);
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
